// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control FSM.
// The JAL state exists only when MC_CTRL_JAL_EN is defined.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        WB_R,
        EXEC_I,
        WB_I,
        MEM_ADDR,
        MEM_RD,
        MEM_WR,
        WB_MEM,
        BRANCH,
        JUMP
`ifdef MC_CTRL_JAL_EN
        , JAL
`endif
    } ctrlState_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the main control FSM (master) and the
// multi-cycle datapath / unified memory (slave).
interface multicycle_control_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2
);
    logic [OPCODE_W-1:0] i_instrCode;
    logic                i_zero;
    logic                i_memReady;
    logic                o_irWrite;
    logic                o_pcWrite;
    logic [1:0]          o_pcSrc;
    logic                o_iorD;
    logic                o_memRead;
    logic                o_memWrite;
    logic [1:0]          o_regDst;
    logic [1:0]          o_memToReg;
    logic                o_regWrite;
    logic                o_aluSrcA;
    logic [1:0]          o_aluSrcB;
    logic [ALUOP_W-1:0]  o_aluOp;
    logic                o_extOp;
    logic                o_instrDone;
    logic                o_illegal;
    logic                o_memErr;

    modport master (
        input  i_instrCode, i_zero, i_memReady,
        output o_irWrite, o_pcWrite, o_pcSrc, o_iorD, o_memRead, o_memWrite,
               o_regDst, o_memToReg, o_regWrite, o_aluSrcA, o_aluSrcB,
               o_aluOp, o_extOp, o_instrDone, o_illegal, o_memErr
    );

    modport slave (
        output i_instrCode, i_zero, i_memReady,
        input  o_irWrite, o_pcWrite, o_pcSrc, o_iorD, o_memRead, o_memWrite,
               o_regDst, o_memToReg, o_regWrite, o_aluSrcA, o_aluSrcB,
               o_aluOp, o_extOp, o_instrDone, o_illegal, o_memErr
    );
endinterface

// File: rtl/mc_mem_wait_timer.sv
// Memory wait counter: counts cycles without ready while enabled and flags
// a timeout when the count reaches MEM_TIMEOUT with ready still low.
module mc_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clear,
    input  logic countEn,
    input  logic ready,
    output logic timeout
);
    logic [TMR_W-1:0] waitCnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || clear) begin
            waitCnt <= '0;
        end else if (countEn && !ready) begin
            waitCnt <= waitCnt + TMR_W'(1);
        end
    end

    assign timeout = countEn && !ready && (waitCnt == TMR_W'(MEM_TIMEOUT));
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM (optional JAL support: MC_CTRL_JAL_EN).
// Outputs decode from the current state, gated by memory ready and ALU zero.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 4
) (
    input logic                 i_clk,
    input logic                 i_rst,
    multicycle_control_if.master bus
);
    ctrlState_e          state, stateNext;
    logic                waitEn, waitClear, waitTimeout;
    logic [OPCODE_W-1:0] opcode;

    assign opcode = bus.i_instrCode;
    assign waitEn = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    // A timed-out fetch stays in FETCH, so the counter also restarts on timeout.
    assign waitClear = (stateNext != state) || waitTimeout;

    mc_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TMR_W      (TMR_W)
    ) u_waitTimer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .clear  (waitClear),
        .countEn(waitEn),
        .ready  (bus.i_memReady),
        .timeout(waitTimeout)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= FETCH;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext       = state;
        bus.o_irWrite   = 1'b0;
        bus.o_pcWrite   = 1'b0;
        bus.o_pcSrc     = PC_ALU;
        bus.o_iorD      = 1'b0;
        bus.o_memRead   = 1'b0;
        bus.o_memWrite  = 1'b0;
        bus.o_regDst    = DST_RT;
        bus.o_memToReg  = M2R_ALUOUT;
        bus.o_regWrite  = 1'b0;
        bus.o_aluSrcA   = 1'b0;
        bus.o_aluSrcB   = SRCB_RT;
        bus.o_aluOp     = ALUOP_W'(ALU_ADD);
        bus.o_extOp     = 1'b0;
        bus.o_instrDone = 1'b0;
        bus.o_illegal   = 1'b0;
        bus.o_memErr    = 1'b0;

        if (i_rst) begin
            // Static fetch values only; no ready-gated strobes while in reset.
            stateNext      = FETCH;
            bus.o_memRead  = 1'b1;
            bus.o_aluSrcB  = SRCB_FOUR;
        end else begin
            case (state)
                FETCH: begin
                    bus.o_memRead = 1'b1;
                    bus.o_aluSrcB = SRCB_FOUR;
                    if (bus.i_memReady) begin
                        bus.o_irWrite = 1'b1;
                        bus.o_pcWrite = 1'b1;
                        stateNext     = DECODE;
                    end else if (waitTimeout) begin
                        bus.o_memRead = 1'b0;
                        bus.o_memErr  = 1'b1;
                    end
                end
                DECODE: begin
                    bus.o_aluSrcB = SRCB_IMMSH2;
                    bus.o_extOp   = 1'b1;
                    case (opcode)
                        OPCODE_W'(OP_RTYPE):                    stateNext = EXEC_R;
                        OPCODE_W'(OP_ADDI), OPCODE_W'(OP_ADDIU): stateNext = EXEC_I;
                        OPCODE_W'(OP_LW), OPCODE_W'(OP_SW):      stateNext = MEM_ADDR;
                        OPCODE_W'(OP_BEQ), OPCODE_W'(OP_BNE):    stateNext = BRANCH;
                        OPCODE_W'(OP_J):                        stateNext = JUMP;
`ifdef MC_CTRL_JAL_EN
                        OPCODE_W'(OP_JAL):                      stateNext = JAL;
`endif
                        default: begin
                            bus.o_illegal   = 1'b1;
                            bus.o_instrDone = 1'b1;
                            stateNext       = FETCH;
                        end
                    endcase
                end
                EXEC_R: begin
                    bus.o_aluSrcA = 1'b1;
                    bus.o_aluOp   = ALUOP_W'(ALU_FUNCT);
                    stateNext     = WB_R;
                end
                WB_R: begin
                    bus.o_regDst    = DST_RD;
                    bus.o_regWrite  = 1'b1;
                    bus.o_instrDone = 1'b1;
                    stateNext       = FETCH;
                end
                EXEC_I, MEM_ADDR: begin
                    bus.o_aluSrcA = 1'b1;
                    bus.o_aluSrcB = SRCB_IMM;
                    bus.o_extOp   = 1'b1;
                    if (state == EXEC_I)                  stateNext = WB_I;
                    else if (opcode == OPCODE_W'(OP_SW)) stateNext = MEM_WR;
                    else                                  stateNext = MEM_RD;
                end
                WB_I: begin
                    bus.o_regWrite  = 1'b1;
                    bus.o_instrDone = 1'b1;
                    stateNext       = FETCH;
                end
                MEM_RD: begin
                    bus.o_iorD    = 1'b1;
                    bus.o_memRead = 1'b1;
                    if (bus.i_memReady) begin
                        stateNext = WB_MEM;
                    end else if (waitTimeout) begin
                        bus.o_memRead = 1'b0;
                        bus.o_memErr  = 1'b1;
                        stateNext     = FETCH;
                    end
                end
                MEM_WR: begin
                    bus.o_iorD     = 1'b1;
                    bus.o_memWrite = 1'b1;
                    if (bus.i_memReady) begin
                        bus.o_instrDone = 1'b1;
                        stateNext       = FETCH;
                    end else if (waitTimeout) begin
                        bus.o_memWrite = 1'b0;
                        bus.o_memErr   = 1'b1;
                        stateNext      = FETCH;
                    end
                end
                WB_MEM: begin
                    bus.o_memToReg  = M2R_MDR;
                    bus.o_regWrite  = 1'b1;
                    bus.o_instrDone = 1'b1;
                    stateNext       = FETCH;
                end
                BRANCH: begin
                    bus.o_aluSrcA   = 1'b1;
                    bus.o_aluOp     = ALUOP_W'(ALU_SUB);
                    bus.o_pcSrc     = PC_ALUOUT;
                    bus.o_pcWrite   = (opcode == OPCODE_W'(OP_BNE)) ? ~bus.i_zero : bus.i_zero;
                    bus.o_instrDone = 1'b1;
                    stateNext       = FETCH;
                end
                JUMP: begin
                    bus.o_pcSrc     = PC_JUMP;
                    bus.o_pcWrite   = 1'b1;
                    bus.o_instrDone = 1'b1;
                    stateNext       = FETCH;
                end
`ifdef MC_CTRL_JAL_EN
                JAL: begin
                    bus.o_regDst    = DST_RA;
                    bus.o_memToReg  = M2R_PC;
                    bus.o_regWrite  = 1'b1;
                    bus.o_pcSrc     = PC_JUMP;
                    bus.o_pcWrite   = 1'b1;
                    bus.o_instrDone = 1'b1;
                    stateNext       = FETCH;
                end
`endif
                default: stateNext = FETCH;
            endcase
        end
    end
endmodule
